// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter with a one-byte hold buffer.
//
// Frame on tx: start (0), data bits 0..7 LSB first, optional parity, stop (1).
// Each bit lasts CLKS_PER_BIT clk cycles. A byte written during a frame is parked
// in the hold buffer and sent back-to-back with no idle gap. A byte written while
// the hold buffer is full is dropped and flagged on overrun.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   PARITY_EN     1 = insert a parity bit between data bit 7 and the stop bit
//   PARITY_ODD    1 = odd parity, 0 = even parity (ignored when PARITY_EN = 0)
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   datain   byte to transmit, sampled only when wrsig = 1
//   wrsig    one-cycle write strobe
//   tx       serial line, idle high, registered
//   idle     high when no frame is in progress and the hold buffer is empty
//   overrun  one-cycle pulse when a written byte is dropped
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] datain,
  input  logic       wrsig,
  output logic       tx,
  output logic       idle,
  output logic       overrun
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             PAR_EN     = (PARITY_EN != 0);
  localparam logic             PAR_ODD    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;

  // Bit boundary of the current bit and the final cycle of the stop bit.
  logic bit_done_c;
  logic last_stop_c;

  assign bit_done_c  = (cnt_q == '0);
  assign last_stop_c = (state_q == S_STOP) && bit_done_c;

  // Transmit FSM, bit timer, shift register, hold buffer and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx          <= 1'b1;
      idle        <= 1'b1;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;

      case (state_q)
        S_IDLE: begin
          tx <= 1'b1;
          if (wrsig) begin
            shift_q   <= datain;
            parity_q  <= (^datain) ^ PAR_ODD;
            state_q   <= S_START;
            cnt_q     <= CNT_RELOAD;
            bit_idx_q <= '0;
            tx        <= 1'b0;
            idle      <= 1'b0;
          end
        end

        S_START: begin
          if (bit_done_c) begin
            state_q   <= S_DATA;
            cnt_q     <= CNT_RELOAD;
            bit_idx_q <= '0;
            tx        <= shift_q[0];
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_DATA: begin
          if (bit_done_c) begin
            cnt_q <= CNT_RELOAD;
            if (bit_idx_q == 3'd7) begin
              if (PAR_EN) begin
                state_q <= S_PARITY;
                tx      <= parity_q;
              end else begin
                state_q <= S_STOP;
                tx      <= 1'b1;
              end
            end else begin
              // Next data bit is always at position 1 before the shift lands.
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx        <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_PARITY: begin
          if (bit_done_c) begin
            state_q <= S_STOP;
            cnt_q   <= CNT_RELOAD;
            tx      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_STOP: begin
          if (bit_done_c) begin
            if (hold_full_q) begin
              // Pending byte starts immediately; a write this cycle refills the buffer.
              shift_q     <= hold_q;
              parity_q    <= (^hold_q) ^ PAR_ODD;
              state_q     <= S_START;
              cnt_q       <= CNT_RELOAD;
              bit_idx_q   <= '0;
              tx          <= 1'b0;
              hold_full_q <= wrsig;
              if (wrsig) begin
                hold_q <= datain;
              end
            end else if (wrsig) begin
              shift_q   <= datain;
              parity_q  <= (^datain) ^ PAR_ODD;
              state_q   <= S_START;
              cnt_q     <= CNT_RELOAD;
              bit_idx_q <= '0;
              tx        <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              tx      <= 1'b1;
              idle    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          tx      <= 1'b1;
          idle    <= 1'b1;
        end
      endcase

      // Writes arriving mid-frame go to the hold buffer, or are dropped if it is full.
      if (wrsig && (state_q != S_IDLE) && !last_stop_c) begin
        if (hold_full_q) begin
          overrun <= 1'b1;
        end else begin
          hold_q      <= datain;
          hold_full_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0, 1 = insert parity bit between last data bit and stop bit.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 datain  input  8  byte to transmit; sampled only in a cycle where wrsig=1.
REQ-007 wrsig  input  1  one-cycle write strobe from the byte source.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 idle  output  1  high when no frame is in progress and the hold buffer is empty.
REQ-010 overrun  output  1  one-cycle pulse when a written byte is dropped.

Function
REQ-011 Frame SHALL be: start (0), data bits 0..7 LSB first, optional parity, stop (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-012 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with PARITY_EN=1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions SHALL be: IDLE->START on accepted byte; START->DATA after one bit time; DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after bit 7; PARITY->STOP after one bit time.
REQ-015 STOP SHALL exit to START if a byte is pending, else to IDLE.
REQ-016 Bit timing SHALL use a down-counter reloaded to CLKS_PER_BIT-1 at each bit boundary.
REQ-017 A 3-bit index SHALL track the current data bit.
REQ-018 tx SHALL be driven from a register, with no combinational path from any input.
REQ-019 wrsig in IDLE with the hold buffer empty at cycle N SHALL load the shift register; tx SHALL go low at N+1.
REQ-020 wrsig during a frame with the hold buffer empty SHALL capture datain into the one-byte hold buffer.
REQ-021 wrsig with the hold buffer full SHALL drop the byte; overrun SHALL be 1 for exactly the next cycle; the buffer SHALL be unchanged.
REQ-022 On the last STOP cycle with the buffer full, the buffer SHALL move to the shift register and the next start bit SHALL begin on the following cycle (zero idle gap).
REQ-023 wrsig on the last STOP cycle with the buffer full SHALL load the new byte into the vacated buffer; no overrun.
REQ-024 wrsig on the last STOP cycle with the buffer empty SHALL load the shift register directly, and the next start bit SHALL follow with zero gap.
REQ-025 Parity bit SHALL be the XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-026 idle SHALL be registered; it falls the cycle after an accepted write and rises the cycle after the final STOP cycle when nothing is pending.

Reset
REQ-027 While rst_n=0 at a clk edge: tx=1, idle=1, overrun=0, FSM=IDLE, counters=0, hold buffer empty.
REQ-028 Reset mid-frame SHALL abort the frame immediately (tx=1 at that edge) and discard any pending byte.
REQ-029 wrsig asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-030 Reset check: rst_n=0 for 3 cycles -> tx=1, idle=1, overrun=0 throughout and after release.
REQ-031 Single byte: CLKS_PER_BIT=16, datain=0x55 with wrsig at N -> tx=0 for N+1..N+16; tx bits 1,0,1,0,1,0,1,0 (16 cycles each); stop=1 for N+145..N+160; idle=1 at N+161.
REQ-032 Back-to-back: 0xA3 at N, 0x3C at N+5 -> second start bit begins at N+161; idle stays 0 until N+321; overrun never asserts.
REQ-033 Overrun: writes at N, N+5, N+9 -> third byte dropped with overrun=1 only at N+10; the frames for the first two bytes are unaffected.
REQ-034 Parity: PARITY_EN=1, PARITY_ODD=1, datain=0x07 -> parity bit 0, frame 176 cycles; with PARITY_ODD=0 -> parity bit 1.
REQ-035 Mid-frame reset plus paced source: rst_n=0 at N+50 -> tx=1 from that edge and no frame resumes; then wrsig every 255 cycles with incrementing data -> every byte sent in order, overrun stays 0.
